// File: rtl/slow_tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : slow_tick_sequencer
//  Description : Synchronises a slow toggle, turns each toggle into a
//                one-cycle tick, and steps an index through STEPS positions
//                under start / stop / single-step control.
//  Revision    : 1.0  initial release
// ============================================================================
module slow_tick_sequencer #(
    parameter int STEPS = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         slow_in,
    input  logic         start,
    input  logic         stop,
    input  logic         single_step,
    input  logic         loop,
    output logic         tick,
    output logic [W-1:0] index,
    output logic         busy,
    output logic         paused,
    output logic         done
);

    // Last legal position; the advance compares against it explicitly
    // so the index never depends on W-bit wrap-around.
    localparam logic [W-1:0] c_LAST_INDEX = W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_s1;
    logic         r_s2;
    logic         r_prev;
    logic         r_armed;
    logic [1:0]   r_arm_cnt;
    logic         r_tick;
    logic [W-1:0] r_index;
    logic         r_busy;
    logic         r_paused;
    logic         r_done;

    logic         w_e;
    logic         w_at_last;
    logic [W-1:0] w_index_adv;

    // Edge of the synchronised toggle, masked until the pipeline has settled
    // so a high slow_in at reset release does not produce a spurious tick.
    assign w_e         = (r_s2 != r_prev) & r_armed;
    assign w_at_last   = (r_index == c_LAST_INDEX);
    assign w_index_adv = w_at_last ? '0 : (r_index + W'(1));

    // Two-flop synchroniser, previous-value flop, arming counter and tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_prev    <= 1'b0;
            r_armed   <= 1'b0;
            r_arm_cnt <= 2'd0;
            r_tick    <= 1'b0;
        end else begin
            r_s1   <= slow_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_tick <= w_e;
            // armed goes high on the third edge after reset release
            if (!r_armed) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
                r_armed   <= (r_arm_cnt == 2'd2);
            end
        end
    end

    // Sequencer state machine with registered index, busy, paused and done.
    // Requests that are meaningless in the current state are ignored and do
    // not block lower-priority events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_index <= '0;
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_paused <= 1'b0;
                    end else if (single_step) begin
                        r_state  <= S_PAUSED;
                        r_busy   <= 1'b0;
                        r_paused <= 1'b1;
                        r_index  <= w_index_adv;
                        r_done   <= w_at_last;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state  <= S_PAUSED;
                        r_busy   <= 1'b0;
                        r_paused <= 1'b1;
                    end else if (w_e) begin
                        r_index <= w_index_adv;
                        r_done  <= w_at_last;
                        // a non-looping run finishes when it wraps
                        if (w_at_last && !loop) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_paused <= 1'b0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (stop) begin
                        r_state  <= S_IDLE;
                        r_index  <= '0;
                        r_busy   <= 1'b0;
                        r_paused <= 1'b0;
                    end else if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_paused <= 1'b0;
                    end else if (single_step) begin
                        r_index <= w_index_adv;
                        r_done  <= w_at_last;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_index  <= '0;
                    r_busy   <= 1'b0;
                    r_paused <= 1'b0;
                end
            endcase
        end
    end

    assign tick   = r_tick;
    assign index  = r_index;
    assign busy   = r_busy;
    assign paused = r_paused;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_slow_tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slow_tick_sequencer
//  Description : Self-checking bench for slow_tick_sequencer (STEPS=4, W=4).
//                Each slow_in toggle pushes the expected tick event; the
//                monitor pops and compares whenever tick is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slow_tick_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       slow_in;
    logic       start;
    logic       stop;
    logic       single_step;
    logic       loop;
    logic       tick;
    logic [3:0] index;
    logic       busy;
    logic       paused;
    logic       done;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        int         cyc;
        logic [3:0] idx;
        logic       dn;
        logic       bz;
    } exp_t;

    exp_t sb_q[$];

    slow_tick_sequencer #(.STEPS(4), .W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .slow_in     (slow_in),
        .start       (start),
        .stop        (stop),
        .single_step (single_step),
        .loop        (loop),
        .tick        (tick),
        .index       (index),
        .busy        (busy),
        .paused      (paused),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every observed tick must match the oldest entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (reset === 1'b0 && tick === 1'b1) begin
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_tick: tick=1 at cycle %0d index=%0d, required no tick", cyc, index);
            end else begin
                e = sb_q.pop_front();
                if (cyc !== e.cyc || index !== e.idx || done !== e.dn || busy !== e.bz) begin
                    errors = errors + 1;
                    $display("FAIL tick_event: cycle=%0d index=%0d done=%b busy=%b, required cycle=%0d index=%0d done=%b busy=%b",
                             cyc, index, done, busy, e.cyc, e.idx, e.dn, e.bz);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Flip slow_in now; its tick must appear 3 edges later with these values.
    task automatic toggle_push(input logic [3:0] i, input logic d, input logic b);
        exp_t e;
        slow_in = ~slow_in;
        e.cyc = cyc + 3;
        e.idx = i;
        e.dn  = d;
        e.bz  = b;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic pulse_step();
        single_step = 1'b1; step(1); single_step = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; slow_in = 1'b1; start = 1'b0; stop = 1'b0;
        single_step = 1'b0; loop = 1'b0;
        step(3);
        checks++;
        if ({index, tick, busy, paused, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: index=%0d tick=%b busy=%b paused=%b done=%b, required all 0",
                     index, tick, busy, paused, done);
        end
        reset = 1'b0;
        step(20);
        checks++;
        if (index !== 4'd0 || tick !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_settle: index=%0d tick=%b busy=%b, required 0 0 0", index, tick, busy);
        end
    endtask

    task automatic test_run_noloop();
        int d0;
        loop = 1'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || paused !== 1'b0 || index !== 4'd0) begin
            errors++;
            $display("FAIL run_start: busy=%b paused=%b index=%0d, required 1 0 0", busy, paused, index);
        end
        d0 = done_cnt;
        for (int k = 1; k <= 4; k++) begin
            toggle_push(4'(k % 4), k == 4, k != 4);
            step(10);
        end
        checks++;
        if (busy !== 1'b0 || paused !== 1'b0 || index !== 4'd0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL run_finish: busy=%b paused=%b index=%0d dones=%0d, required 0 0 0 1",
                     busy, paused, index, done_cnt - d0);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL run_drain: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_loop();
        int d0;
        loop = 1'b1;
        pulse_start();
        d0 = done_cnt;
        for (int k = 1; k <= 9; k++) begin
            toggle_push(4'(k % 4), (k % 4) == 0, 1'b1);
            step(10);
        end
        checks++;
        if (busy !== 1'b1 || index !== 4'd1 || done_cnt - d0 !== 2 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL loop_end: busy=%b index=%0d dones=%0d pending=%0d, required 1 1 2 0",
                     busy, index, done_cnt - d0, sb_q.size());
        end
        pulse_stop();
        pulse_stop();
        loop = 1'b0;
        checks++;
        if (busy !== 1'b0 || paused !== 1'b0 || index !== 4'd0) begin
            errors++;
            $display("FAIL loop_abort: busy=%b paused=%b index=%0d, required 0 0 0", busy, paused, index);
        end
    endtask

    task automatic test_pause_step();
        pulse_start();
        toggle_push(4'd1, 1'b0, 1'b1); step(10);
        toggle_push(4'd2, 1'b0, 1'b1); step(10);
        pulse_stop();
        checks++;
        if (paused !== 1'b1 || busy !== 1'b0 || index !== 4'd2) begin
            errors++;
            $display("FAIL pause_enter: paused=%b busy=%b index=%0d, required 1 0 2", paused, busy, index);
        end
        toggle_push(4'd2, 1'b0, 1'b0); step(10);
        toggle_push(4'd2, 1'b0, 1'b0); step(10);
        pulse_step();
        checks++;
        if (index !== 4'd3 || done !== 1'b0 || paused !== 1'b1) begin
            errors++;
            $display("FAIL step_one: index=%0d done=%b paused=%b, required 3 0 1", index, done, paused);
        end
        pulse_step();
        checks++;
        if (index !== 4'd0 || done !== 1'b1 || paused !== 1'b1) begin
            errors++;
            $display("FAIL step_wrap: index=%0d done=%b paused=%b, required 0 1 1", index, done, paused);
        end
        step(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b, required 0", done);
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || paused !== 1'b0 || index !== 4'd0) begin
            errors++;
            $display("FAIL resume: busy=%b paused=%b index=%0d, required 1 0 0", busy, paused, index);
        end
        pulse_stop();
        pulse_stop();
    endtask

    task automatic test_priority();
        pulse_start();
        toggle_push(4'd1, 1'b0, 1'b1); step(10);
        // stop lands on the same edge as the tick: pause, no advance
        toggle_push(4'd1, 1'b0, 1'b0);
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        checks++;
        if (paused !== 1'b1 || busy !== 1'b0 || index !== 4'd1) begin
            errors++;
            $display("FAIL stop_vs_tick: paused=%b busy=%b index=%0d, required 1 0 1", paused, busy, index);
        end
        step(10);
        pulse_stop();
        start = 1'b1; single_step = 1'b1;
        step(1);
        start = 1'b0; single_step = 1'b0;
        checks++;
        if (busy !== 1'b1 || paused !== 1'b0 || index !== 4'd0) begin
            errors++;
            $display("FAIL start_vs_step: busy=%b paused=%b index=%0d, required 1 0 0", busy, paused, index);
        end
        pulse_stop();
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        toggle_push(4'd1, 1'b0, 1'b1); step(10);
        toggle_push(4'd2, 1'b0, 1'b1); step(10);
        toggle_push(4'd3, 1'b0, 1'b1); step(3);
        // tick and index=3 are live here; reset lands mid-cycle
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({index, tick, busy, paused, done} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: index=%0d tick=%b busy=%b paused=%b done=%b, required all 0",
                     index, tick, busy, paused, done);
        end
        @(negedge clk);
        reset = 1'b0;
        step(20);
        checks++;
        if (busy !== 1'b0 || paused !== 1'b0 || index !== 4'd0 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_recover: busy=%b paused=%b index=%0d pending=%0d, required 0 0 0 0",
                     busy, paused, index, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_run_noloop();
        test_loop();
        test_pause_step();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
